// File: rtl/mips_pkg.sv
// Shared encodings and the EX-stage shadow record for the hazard/forwarding unit.
package mips_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
        logic             wr;
        logic             ld;
    } ex_shadow_t;

    localparam ex_shadow_t EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Per-operand forwarding priority: EX/MEM producer beats MEM/WB, $0 never forwarded.
module fwd_sel
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_mem_wr,
    input  logic [REG_W-1:0] i_wb_dst,
    input  logic             i_wb_wr,
    output logic [1:0]       o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_wr && (i_mem_dst != '0) && (i_mem_dst == i_src);
    assign w_wb_hit  = i_wb_wr  && (i_wb_dst  != '0) && (i_wb_dst  == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow EX/MEM/WB pipeline tracking with operand forwarding selects,
// load-use stall detection and a saturating stall counter.
module hazard_forward_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    ex_shadow_t       r_ex;
    logic [REG_W-1:0] r_mem_dst;
    logic             r_mem_wr;
    logic [REG_W-1:0] r_wb_dst;
    logic             r_wb_wr;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    ex_shadow_t       w_ex_next;

    // ID -> EX boundary: detect a load in EX feeding the instruction in ID
    assign w_hazard = r_ex.ld && r_ex.wr && (r_ex.dst != '0) && id_valid &&
                      ((id_rs == r_ex.dst) || (id_rt == r_ex.dst));
    assign w_stall  = w_hazard && !flush && !rst;
    assign w_bubble = w_stall || flush || !id_valid;

    always_comb begin
        w_ex_next = EX_BUBBLE;
        if (!w_bubble) begin
            w_ex_next.rs  = id_rs;
            w_ex_next.rt  = id_rt;
            w_ex_next.dst = id_dst;
            w_ex_next.wr  = id_regwrite;
            w_ex_next.ld  = id_memread;
        end
    end

    // EX -> MEM -> WB shadow shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex      <= EX_BUBBLE;
            r_mem_dst <= '0;
            r_mem_wr  <= 1'b0;
            r_wb_dst  <= '0;
            r_wb_wr   <= 1'b0;
        end else begin
            r_ex      <= w_ex_next;
            r_mem_dst <= r_ex.dst;
            r_mem_wr  <= r_ex.wr;
            r_wb_dst  <= r_mem_dst;
            r_wb_wr   <= r_mem_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    fwd_sel u_fwd_a (
        .i_src     (r_ex.rs),
        .i_mem_dst (r_mem_dst),
        .i_mem_wr  (r_mem_wr),
        .i_wb_dst  (r_wb_dst),
        .i_wb_wr   (r_wb_wr),
        .o_sel     (fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_src     (r_ex.rt),
        .i_mem_dst (r_mem_dst),
        .i_mem_wr  (r_mem_wr),
        .i_wb_dst  (r_wb_dst),
        .i_wb_wr   (r_wb_wr),
        .o_sel     (fwd_b)
    );

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed table of ID-stage instructions with hand-computed forwarding/stall results.
module tb_hazard_forward_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_dst;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic       chk;
        logic       rst;
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(string name, logic chk, logic r, logic vld,
                                int rs, int rt, int dst, logic wr, logic ld, logic fl,
                                logic [1:0] fa, logic [1:0] fb, logic st, int cnt);
        vec_t v;
        v.name = name; v.chk = chk; v.rst = r; v.vld = vld;
        v.rs = 5'(rs); v.rt = 5'(rt); v.dst = 5'(dst);
        v.wr = wr; v.ld = ld; v.fl = fl;
        v.fa = fa; v.fb = fb; v.st = st; v.cnt = 4'(cnt);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_dst = v.dst;
        id_regwrite = v.wr; id_memread = v.ld; flush = v.fl;
        #1;
        if (v.chk) begin
            n_vec++;
            if (fwd_a !== v.fa) begin
                n_err++;
                $display("FAIL %s fwd_a: got %b want %b", v.name, fwd_a, v.fa);
            end
            n_vec++;
            if (fwd_b !== v.fb) begin
                n_err++;
                $display("FAIL %s fwd_b: got %b want %b", v.name, fwd_b, v.fb);
            end
            n_vec++;
            if (stall !== v.st) begin
                n_err++;
                $display("FAIL %s stall: got %b want %b", v.name, stall, v.st);
            end
            n_vec++;
            if (stall_cnt !== v.cnt) begin
                n_err++;
                $display("FAIL %s stall_cnt: got %0d want %0d", v.name, stall_cnt, v.cnt);
            end
        end
    endtask

    initial begin
        int exp_cnt;
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;

        //            name          chk rst vld rs rt dst wr ld fl  fa     fb     st cnt
        tbl.push_back(mk("rst0",     0, 1, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("rst1",     1, 1, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("idle",     1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("add3",     1, 0, 1,  1, 2, 3,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("rd3_id",   1, 0, 1,  3, 4, 6,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("rd3_ex",   1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk("w5",       1, 0, 1,  0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("indep",    1, 0, 1,  1, 2, 8,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("rd5_id",   1, 0, 1,  9, 5, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("dist2_ex", 1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b10, 0, 0));
        tbl.push_back(mk("w5a",      1, 0, 1,  0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("w5b",      1, 0, 1,  0, 0, 5,  1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("rd5b_id",  1, 0, 1, 11, 5, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("prio_ex",  1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b01, 0, 0));
        tbl.push_back(mk("lw7",      1, 0, 1,  1, 0, 7,  1, 1, 0, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk("lu_stall", 1, 0, 1,  7, 2, 13, 1, 0, 0, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk("lu_held",  1, 0, 1,  7, 2, 13, 1, 0, 0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("lu_ex",    1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0, 1));
        tbl.push_back(mk("w0",       1, 0, 1,  1, 2, 0,  1, 0, 0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("rd0_id",   1, 0, 1,  0, 0, 14, 1, 0, 0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("rd0_ex",   1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("lw9",      1, 0, 1,  2, 3, 9,  1, 1, 0, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("flush_hz", 1, 0, 1,  9, 0, 15, 1, 0, 1, 2'b00, 2'b00, 0, 1));
        tbl.push_back(mk("post_fl",  1, 0, 0,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 1));

        foreach (tbl[i]) apply(tbl[i]);

        // Twenty load-use pairs drive the 4-bit counter into saturation
        exp_cnt = 1;
        for (int p = 0; p < 20; p++) begin
            apply(mk("sat_lw", 1, 0, 1, 0, 0, 7, 1, 1, 0,
                     (p > 0) ? 2'b10 : 2'b00, 2'b00, 0, exp_cnt));
            apply(mk("sat_stall", 1, 0, 1, 7, 0, 13, 1, 0, 0, 2'b00, 2'b00, 1, exp_cnt));
            if (exp_cnt < 15) exp_cnt++;
            apply(mk("sat_held", 1, 0, 1, 7, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0, exp_cnt));
        end

        // Reset asserted in the cycle that would otherwise stall
        apply(mk("rs_lw",    1, 0, 1, 0, 0, 7,  1, 1, 0, 2'b10, 2'b00, 0, 15));
        apply(mk("rs_stall", 1, 1, 1, 7, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0, 15));
        apply(mk("rs_after", 1, 0, 1, 7, 0, 13, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        apply(mk("rs_rd_ex", 1, 0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the stall performance counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_valid  input  1  the ID-stage slot holds a real instruction.
REQ-005 id_rs  input  5  ID-stage source register A.
REQ-006 id_rt  input  5  ID-stage source register B.
REQ-007 id_dst  input  5  ID-stage destination register.
REQ-008 id_regwrite  input  1  the ID-stage instruction writes id_dst.
REQ-009 id_memread  input  1  the ID-stage instruction is a load.
REQ-010 flush  input  1  a taken branch kills the ID-stage instruction this cycle.
REQ-011 fwd_a  output  2  select for the EX-stage operand-A 3:1 mux.
REQ-012 fwd_b  output  2  select for the EX-stage operand-B 3:1 mux.
REQ-013 stall  output  1  hold PC and IF/ID; inject a bubble into EX.
REQ-014 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 Select codes SHALL be: 00 register-file value, 01 EX/MEM result, 10 MEM/WB result; 11 SHALL never be driven.
REQ-016 The block SHALL keep shadow pipeline state: EX (rs, rt, dst, wr, ld), MEM (dst, wr) and WB (dst, wr).
REQ-017 Each clock SHALL shift the shadow state: WB<=MEM, MEM<=EX, and EX<=ID fields.
REQ-018 EX SHALL instead load a bubble (wr=0, ld=0, rs=rt=dst=0) when any of these holds: stall=1, flush=1, or id_valid=0.
REQ-019 fwd_a SHALL be 01 when MEM.wr=1, MEM.dst!=0 and MEM.dst==EX.rs.
REQ-020 Otherwise fwd_a SHALL be 10 when WB.wr=1, WB.dst!=0 and WB.dst==EX.rs.
REQ-021 Otherwise fwd_a SHALL be 00; fwd_b SHALL follow the same rules using EX.rt.
REQ-022 The EX/MEM match SHALL take priority over the MEM/WB match (youngest producer wins).
REQ-023 Register 0 SHALL never be forwarded.
REQ-024 fwd_a and fwd_b SHALL be combinational from shadow registers only, with zero added latency: valid in the same cycle the instruction is in EX.
REQ-025 A load-use hazard SHALL be: EX.ld=1, EX.wr=1, EX.dst!=0, id_valid=1, and (id_rs==EX.dst or id_rt==EX.dst).
REQ-026 stall SHALL equal hazard AND NOT flush AND NOT rst; it is combinational and lasts exactly one cycle per load-use pair, because the bubble clears EX.ld.
REQ-027 When flush and a hazard coincide, flush SHALL win: stall=0 and EX loads a bubble.
REQ-028 A WB-stage write to a register read in ID SHALL NOT be handled here; the register file is write-before-read.
REQ-029 stall_cnt SHALL increment by 1 on each clock where stall=1, and SHALL hold at all-ones without wrapping.

Reset
REQ-030 While rst=1 at a clock edge, all shadow state SHALL clear to bubble and stall_cnt SHALL clear to 0.
REQ-031 Consequently, the cycle after reset SHALL show fwd_a=fwd_b=00, stall=0 and stall_cnt=0.
REQ-032 stall SHALL be forced to 0 during any cycle with rst=1.
REQ-033 An assertion of rst in the middle of a stall SHALL discard the pending hazard, with no extra bubble after reset.

Structure
REQ-034 Package mips_pkg SHALL hold: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, REG_W=5, and a typedef for the EX shadow record.
REQ-035 The per-operand priority comparator SHALL be one sub-module, fwd_sel, instantiated twice (operand A and operand B).
REQ-036 The output selects SHALL drive the existing EX-stage 3:1 operand muxes directly.

Verification
REQ-037 Back-to-back ALU ops:
- add $3 (dst=3, wr) then an instruction with rs=3, rt=4.
- Required: fwd_a=01 and fwd_b=00 in the second instruction's EX cycle.
REQ-038 Distance-two dependency:
- dst=5 writer, one independent instruction, then a reader with rt=5.
- Required: fwd_b=10.
- Repeat with both MEM and WB writing $5: required fwd_b=01.
REQ-039 Load-use:
- lw dst=7 followed by a reader with rs=7.
- Required: stall=1 for exactly 1 cycle, stall_cnt goes 0->1, then fwd_a=10 in the reader's EX cycle.
REQ-040 Register 0 and flush:
- Writer with dst=0 followed by a reader with rs=0: required fwd_a=00.
- Load-use pair with flush=1 in the hazard cycle: required stall=0 and stall_cnt unchanged.
REQ-041 Counter saturation and reset:
- With CNT_W=4, drive 20 load-use pairs: required stall_cnt=15.
- Assert rst during a stall cycle: required stall=0 that cycle, then stall_cnt=0 and fwd_a=fwd_b=00.
